// File: rtl/cordic_fixedpoint_get_phase_addr_enc_if.sv
// rtl/cordic_fixedpoint_get_phase_addr_enc_if.sv - beat handshake and data bundle for the phase address encoder
interface cordic_fixedpoint_get_phase_addr_enc_if;
   logic        iValid;
   logic        oReady;
   logic [15:0] iPhase_cmp_C;
   logic [20:0] iPhase_abs;
   logic        iPhase_sign;
   logic        oValid;
   logic        iReady;
   logic [4:0]  oAddr;
   logic [20:0] oPhase_abs;
   logic        oPhase_sign;
   logic        oBubble;
   logic [7:0]  oBubble_cnt;

   modport slave (
      input  iValid, iPhase_cmp_C, iPhase_abs, iPhase_sign, iReady,
      output oReady, oValid, oAddr, oPhase_abs, oPhase_sign, oBubble, oBubble_cnt
   );

   modport master (
      output iValid, iPhase_cmp_C, iPhase_abs, iPhase_sign, iReady,
      input  oReady, oValid, oAddr, oPhase_abs, oPhase_sign, oBubble, oBubble_cnt
   );
endinterface

// File: rtl/cordic_fixedpoint_get_phase_addr_enc.sv
// rtl/cordic_fixedpoint_get_phase_addr_enc.sv - two-stage thermometer-to-address encoder with bubble detection
module cordic_fixedpoint_get_phase_addr_enc (
   input  logic                                   iClk,
   input  logic                                   iRst_n,
   cordic_fixedpoint_get_phase_addr_enc_if.slave  bus
);
   logic        s1_valid_q, s1_valid_d;
   logic [15:0] s1_cmp_q, s1_cmp_d;
   logic [20:0] s1_abs_q, s1_abs_d;
   logic        s1_sign_q, s1_sign_d;

   logic        s2_valid_q, s2_valid_d;
   logic [4:0]  s2_addr_q, s2_addr_d;
   logic [20:0] s2_abs_q, s2_abs_d;
   logic        s2_sign_q, s2_sign_d;
   logic        s2_bubble_q, s2_bubble_d;
   logic [7:0]  bubble_cnt_q, bubble_cnt_d;

   logic        s2_load;
   logic        s1_adv;
   logic [4:0]  enc_addr;
   logic        enc_found;
   logic        enc_bubble;

   assign s2_load = !s2_valid_q | bus.iReady;
   assign s1_adv  = !s1_valid_q | s2_load;

   // Address is the run length of ones from bit 0; any one after the first zero is a bubble.
   always_comb begin
      enc_addr   = 5'd16;
      enc_found  = 1'b0;
      enc_bubble = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (!s1_cmp_q[k]) begin
            if (!enc_found) begin
               enc_addr = 5'(k);
            end
            enc_found = 1'b1;
         end else if (enc_found) begin
            enc_bubble = 1'b1;
         end
      end
   end

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_cmp_d     = s1_cmp_q;
      s1_abs_d     = s1_abs_q;
      s1_sign_d    = s1_sign_q;
      s2_valid_d   = s2_valid_q;
      s2_addr_d    = s2_addr_q;
      s2_abs_d     = s2_abs_q;
      s2_sign_d    = s2_sign_q;
      s2_bubble_d  = s2_bubble_q;
      bubble_cnt_d = bubble_cnt_q;

      if (s1_adv) begin
         s1_valid_d = bus.iValid;
         if (bus.iValid) begin
            s1_cmp_d  = bus.iPhase_cmp_C;
            s1_abs_d  = bus.iPhase_abs;
            s1_sign_d = bus.iPhase_sign;
         end
      end

      if (s2_load) begin
         s2_valid_d  = s1_valid_q;
         // Clearing the flag on an empty load keeps oBubble low whenever oValid is low.
         s2_bubble_d = s1_valid_q & enc_bubble;
         if (s1_valid_q) begin
            s2_addr_d = enc_addr;
            s2_abs_d  = s1_abs_q;
            s2_sign_d = s1_sign_q;
            if (enc_bubble && (bubble_cnt_q != 8'hFF)) begin
               bubble_cnt_d = bubble_cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         s1_valid_q   <= 1'b0;
         s1_cmp_q     <= '0;
         s1_abs_q     <= '0;
         s1_sign_q    <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_addr_q    <= '0;
         s2_abs_q     <= '0;
         s2_sign_q    <= 1'b0;
         s2_bubble_q  <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_cmp_q     <= s1_cmp_d;
         s1_abs_q     <= s1_abs_d;
         s1_sign_q    <= s1_sign_d;
         s2_valid_q   <= s2_valid_d;
         s2_addr_q    <= s2_addr_d;
         s2_abs_q     <= s2_abs_d;
         s2_sign_q    <= s2_sign_d;
         s2_bubble_q  <= s2_bubble_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // Reset gating keeps oReady low for the whole time reset is held.
   assign bus.oReady      = iRst_n & s1_adv;
   assign bus.oValid      = s2_valid_q;
   assign bus.oAddr       = s2_addr_q;
   assign bus.oPhase_abs  = s2_abs_q;
   assign bus.oPhase_sign = s2_sign_q;
   assign bus.oBubble     = s2_bubble_q;
   assign bus.oBubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_cordic_fixedpoint_get_phase_addr_enc.sv
// tb/tb_cordic_fixedpoint_get_phase_addr_enc.sv - randomized scoreboard bench for the phase address encoder
module tb_cordic_fixedpoint_get_phase_addr_enc;
   typedef struct {
      logic [15:0] c;
      logic [20:0] a;
      logic        s;
      int          t;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cordic_fixedpoint_get_phase_addr_enc_if bus();

   cordic_fixedpoint_get_phase_addr_enc dut (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus)
   );

   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    exp_cnt = 0;
   bit    showing = 1'b0;
   bit    lat_chk = 1'b0;
   beat_t pend[$];
   beat_t q[$];
   beat_t cur;

   logic        s_ordy, s_ovalid, s_bubble, s_sign;
   logic [4:0]  s_addr;
   logic [20:0] s_abs;
   logic [7:0]  s_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int ref_addr(input logic [15:0] c);
      int n = 0;
      while (n < 16 && c[n]) n++;
      return n;
   endfunction

   function automatic bit ref_bubble(input logic [15:0] c);
      return 32'(c) != ((32'd1 << ref_addr(c)) - 1);
   endfunction

   function automatic beat_t mk(input logic [15:0] c, input logic [20:0] a, input logic s);
      beat_t b;
      b.c = c; b.a = a; b.s = s; b.t = 0;
      return b;
   endfunction

   function automatic logic [15:0] rand_code();
      logic [15:0] c;
      if ($urandom_range(1) == 1) c = 16'((32'd1 << $urandom_range(16)) - 1);
      else                        c = 16'($urandom);
      return c;
   endfunction

   task automatic model_clear();
      pend.delete();
      q.delete();
      exp_cnt = 0;
      showing = 1'b0;
   endtask

   task automatic drive(input int vprob, input int rprob);
      if (pend.size() > 0) cur = pend[0];
      else cur = mk(16'($urandom), 21'($urandom), 1'($urandom));
      bus.iValid       = (pend.size() > 0) && ($urandom_range(99) < vprob);
      bus.iPhase_cmp_C = cur.c;
      bus.iPhase_abs   = cur.a;
      bus.iPhase_sign  = cur.s;
      bus.iReady       = $urandom_range(99) < rprob;
   endtask

   task automatic step();
      beat_t b;
      @(negedge clk);
      cyc++;
      s_ordy   = bus.oReady;
      s_ovalid = bus.oValid;
      s_cnt    = bus.oBubble_cnt;
      if (bus.oValid) begin
         s_addr = bus.oAddr; s_abs = bus.oPhase_abs; s_sign = bus.oPhase_sign; s_bubble = bus.oBubble;
         if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            b = q[0];
            if (!showing) begin
               if (ref_bubble(b.c) && exp_cnt < 255) exp_cnt++;
               if (lat_chk) chk("latency", cyc - b.t, 2);
               showing = 1'b1;
            end
            chk("addr", bus.oAddr, ref_addr(b.c));
            chk("bubble", bus.oBubble, ref_bubble(b.c));
            chk("abs", bus.oPhase_abs, b.a);
            chk("sign", bus.oPhase_sign, b.s);
         end
      end else begin
         chk("bubble_idle", bus.oBubble, 0);
      end
      chk("bubble_cnt", bus.oBubble_cnt, exp_cnt);
      if (bus.iValid && bus.oReady) begin
         cur.t = cyc;
         q.push_back(cur);
         void'(pend.pop_front());
      end
      if (bus.oValid && bus.iReady && q.size() > 0) begin
         void'(q.pop_front());
         showing = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int vprob, input int rprob, input int budget);
      int n = 0;
      while ((pend.size() > 0 || q.size() > 0) && n < budget) begin
         drive(vprob, rprob);
         step();
         n++;
      end
      if (n >= budget) chk("timeout", 1, 0);
      bus.iValid = 1'b0;
   endtask

   initial begin
      bus.iValid = 1'b0; bus.iReady = 1'b0;
      bus.iPhase_cmp_C = '0; bus.iPhase_abs = '0; bus.iPhase_sign = 1'b0;
      #2;
      chk("rst_ovalid", bus.oValid, 0);
      chk("rst_oready", bus.oReady, 0);
      chk("rst_addr", bus.oAddr, 0);
      chk("rst_abs", bus.oPhase_abs, 0);
      chk("rst_cnt", bus.oBubble_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("rel_oready", bus.oReady, 1);

      // thermometer sweep, back-to-back with fixed latency
      lat_chk = 1'b1;
      for (int k = 0; k <= 16; k++) pend.push_back(mk(16'((32'd1 << k) - 1), 21'(k), 1'(k)));
      run(100, 100, 100);
      lat_chk = 1'b0;
      chk("sweep_last_addr", s_addr, 16);
      chk("sweep_cnt", s_cnt, 0);

      pend.push_back(mk(16'h0005, 21'h0, 1'b0));
      pend.push_back(mk(16'h00F0, 21'h1, 1'b0));
      run(100, 100, 100);
      chk("bub_last_addr", s_addr, 0);
      chk("bub_last_flag", s_bubble, 1);
      chk("bub_cnt", s_cnt, 2);

      pend.push_back(mk(16'h00FF, 21'h1ABCDE, 1'b1));
      run(100, 100, 100);
      chk("pt_addr", s_addr, 8);
      chk("pt_abs", s_abs, 21'h1ABCDE);
      chk("pt_sign", s_sign, 1);

      // backpressure: A..D offered continuously, sink stalled for 4 cycles
      for (int k = 0; k < 4; k++) pend.push_back(mk(16'((32'd1 << (k + 3)) - 1), 21'(k + 100), 1'b0));
      for (int i = 0; i < 10; i++) begin
         drive(100, 100);
         bus.iReady = (i >= 4);
         step();
         if (i == 2 || i == 3) chk("bp_oready_low", s_ordy, 0);
         if (i >= 4 && i <= 7) chk("bp_no_gap", s_ovalid, 1);
      end
      chk("bp_drained", q.size() + pend.size(), 0);

      // reset with both stages holding bubble beats
      pend.push_back(mk(16'h0002, 21'h55, 1'b1));
      pend.push_back(mk(16'h0004, 21'h66, 1'b0));
      for (int i = 0; i < 2; i++) begin
         drive(100, 0);
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ovalid", bus.oValid, 0);
      chk("mid_rst_cnt", bus.oBubble_cnt, 0);
      chk("mid_rst_oready", bus.oReady, 0);
      chk("mid_rst_bubble", bus.oBubble, 0);
      model_clear();
      bus.iValid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("mid_rel_oready", bus.oReady, 1);
      pend.push_back(mk(16'h0007, 21'h12345, 1'b1));
      run(100, 100, 100);
      chk("post_rst_first_abs", s_abs, 21'h12345);

      for (int i = 0; i < 10000; i++) pend.push_back(mk(rand_code(), 21'($urandom), 1'($urandom)));
      run(50, 50, 70000);

      for (int i = 0; i < 300; i++) pend.push_back(mk(16'($urandom_range(1, 32767) << 1), 21'(i), 1'b0));
      run(100, 100, 1000);
      chk("sat_cnt", s_cnt, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cordic_fixedpoint_get_phase_addr_enc.md
CORDIC_FIXEDPOINT_GET_PHASE_ADDR_ENC -- requirements
Module: cordic_fixedpoint_get_phase_addr_enc

Interface
REQ-001 Parameters: none; widths are fixed at 16 comparator bits, 21-bit phase magnitude and 5-bit address.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, as listed in REQ-003 and REQ-004.
REQ-003 iClk  in  1  single clock; all state updates on its rising edge.
REQ-004 iRst_n  in  1  asynchronous active-low reset.
REQ-005 iValid  in  1  upstream beat valid.
REQ-006 oReady  out  1  block can accept a beat this cycle.
REQ-007 iPhase_cmp_C  in  16  comparator vector; bit k = (|z| > C[k]), C ascending.
REQ-008 iPhase_abs  in  21  |z|, carried alongside the code.
REQ-009 iPhase_sign  in  1  sign of z, carried alongside the code.
REQ-010 oValid  out  1  output beat valid.
REQ-011 iReady  in  1  downstream accepts the beat this cycle.
REQ-012 oAddr  out  5  phase ROM address, range 0..16.
REQ-013 oPhase_abs  out  21  registered copy of iPhase_abs for this beat.
REQ-014 oPhase_sign  out  1  registered copy of iPhase_sign for this beat.
REQ-015 oBubble  out  1  the current output beat had a non-thermometer code.
REQ-016 oBubble_cnt  out  8  saturating count of accepted bubble beats.

Function
- REQ-017 Transfers:
  - Input transfer = iValid & oReady.
  - Output transfer = oValid & iReady.
- REQ-018 Pipeline structure:
  - Two register stages, S1 and S2, each with its own valid flag.
  - S1 captures the raw inputs.
  - S2 holds the encoded result and drives all o* data ports.
- REQ-019 Advance rules:
  - S2 loads when (!S2.valid | iReady).
  - S1 advances when (!S1.valid | S2 loads).
  - oReady = !S1.valid | S2 loads (combinational from iReady is permitted).
- REQ-020 Latency and throughput:
  - With iReady held high, a beat accepted at edge N appears on oValid/oAddr after edge N+2.
  - Throughput is 1 beat per cycle.
- REQ-021 Encoding: oAddr = number of contiguous 1s counted upward from bit 0 of iPhase_cmp_C.
  - 16'h0000 gives 0; 16'h0001 gives 1; 16'hFFFF gives 16.
- REQ-022 Bubble detection: oBubble = 1 iff any bit above the first 0 is 1 (e.g. 16'h0005).
  - oAddr still follows REQ-021 (16'h0005 gives 1).
- REQ-023 Bubble counter: oBubble_cnt increments once per S2 load carrying a bubble.
  - It saturates at 255.
  - It is not affected by output stalls.
- REQ-024 Backpressure: while oValid=1 and iReady=0, S2 contents and oValid SHALL hold stable.
  - S1 accepts at most one further beat.
  - Then oReady=0.
- REQ-025 Ordering: no beat is dropped, duplicated or reordered under any iValid/iReady pattern.
- REQ-026 Simultaneous events: with S1 full, S2 full and iReady=1 in the same cycle, in one edge:
  - S2 takes S1;
  - S1 takes the new beat if iValid=1.
- REQ-027 Data while invalid: when a valid flag is 0, the associated data registers MAY hold stale values.
  - oAddr/oPhase_* are don't-care while oValid=0.
  - oBubble SHALL be 0 while oValid=0.

Reset
- REQ-028 Reset assertion (iRst_n=0), asynchronously and irrespective of iClk:
  - S1.valid=0, S2.valid=0, oValid=0;
  - oAddr=0, oPhase_abs=0, oPhase_sign=0;
  - oBubble=0, oBubble_cnt=0.
- REQ-029 While iRst_n=0, oReady SHALL be 0.
- REQ-030 Reset mid-operation discards all in-flight beats; no beat from before reset appears afterwards.
- REQ-031 After iRst_n deasserts, oReady=1 in the first cycle, and a beat is accepted on the first rising edge.

Verification
- REQ-032 Thermometer sweep: iReady=1; feed codes 16'h0000, 16'h0001, 16'h0003 ... 16'hFFFF back-to-back.
  - Expect oAddr 0..16 in order, each 2 cycles after input.
  - Expect oBubble=0 and oBubble_cnt=0.
- REQ-033 Bubble: feed 16'h0005, then 16'h00F0.
  - Expect oAddr=1, oBubble=1, then oAddr=0, oBubble=1.
  - Expect oBubble_cnt=2.
  - Also feed 300 bubble beats and expect oBubble_cnt=255.
- REQ-034 Backpressure: iValid=1 continuously with beats A, B, C, D; iReady=0 for 4 cycles, then 1.
  - Expect A held on outputs and oReady=0 after B is captured.
  - Then A, B, C, D emerge in order with no gaps.
- REQ-035 Passthrough: iPhase_abs=21'h1ABCDE, iPhase_sign=1, code 16'h00FF.
  - Expect oPhase_abs=21'h1ABCDE, oPhase_sign=1, oAddr=8.
- REQ-036 Reset mid-stream: assert iRst_n=0 with both stages full.
  - Expect oValid=0 and oBubble_cnt=0 immediately, before the next clock edge.
  - After release, the first output is the first beat fed post-reset.
- REQ-037 Random: random iValid/iReady at 50% with a scoreboard model.
  - Run 10000 beats.
  - Expect exact match on every beat and stable outputs during every stall.
